// File: rtl/apa102_in_if.sv
// apa102_in_if: write-side bus of the APA102 stream receiver.
// Carries the word writes into frame memory and the refresh status pulses.
//   write_address  word address of the current write
//   write_data     16-bit word data
//   write_strobe   one-clk write pulse
//   frame_done     one-clk pulse when a refresh ends
//   frame_error    one-clk pulse on a malformed frame
// master: the receiver (drives everything); slave: the memory/status consumer.
interface apa102_in_if #(
  parameter int ADDRESS_BUS_WIDTH = 16
);
  logic [ADDRESS_BUS_WIDTH-1:0] write_address;
  logic [15:0]                  write_data;
  logic                         write_strobe;
  logic                         frame_done;
  logic                         frame_error;

  modport master (
    output write_address,
    output write_data,
    output write_strobe,
    output frame_done,
    output frame_error
  );

  modport slave (
    input write_address,
    input write_data,
    input write_strobe,
    input frame_done,
    input frame_error
  );
endinterface

// File: rtl/apa102_in.sv
// apa102_in: APA102 stream receiver.
// Samples an external APA102 clock/data pair, finds the 32-zero start frame,
// and turns each LED frame into two 16-bit word writes (high word, then low
// word on the next cycle) at consecutive addresses starting at start_address.
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   sck, sdi       APA102 clock/data from pins, asynchronous to clk
//   start_address  first word address after each start frame
//   word_count     maximum words written per refresh (0 disables writes)
//   bus            apa102_in_if master: write_address/write_data/write_strobe,
//                  frame_done, frame_error
module apa102_in #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES    = 4800
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sck,
  input  logic                         sdi,
  input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
  input  logic [ADDRESS_BUS_WIDTH-1:0] word_count,
  apa102_in_if.master                  bus
);

  localparam int AW   = ADDRESS_BUS_WIDTH;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  localparam logic [1:0] FR_LED   = 2'd0;
  localparam logic [1:0] FR_START = 2'd1;
  localparam logic [1:0] FR_BAD   = 2'd2;

  // LED frames carry 111 in the brightness header; an all-zero word is a
  // fresh start frame; anything else means we lost alignment.
  function automatic logic [1:0] classify(input logic [31:0] f);
    if (f[31:29] == 3'b111) return FR_LED;
    if (f == 32'd0)         return FR_START;
    return FR_BAD;
  endfunction

  logic            sck_p0, sck_p1, sck_p2;
  logic            sdi_p0, sdi_p1;
  logic            sck_rise;
  logic            bit_in;

  logic [1:0]      state;
  logic [5:0]      zero_cnt;
  logic [5:0]      bit_cnt;
  logic [31:0]     shift_q;
  logic [AW-1:0]   word_cnt;
  logic [AW-1:0]   word_limit;
  logic [TO_W-1:0] to_cnt;
  logic            pend_lo;
  logic            timeout_hit;
  logic [31:0]     frame_full;

  // ---- stage: pin synchronizers and sck edge detect ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_p0 <= 1'b0;
      sck_p1 <= 1'b0;
      sck_p2 <= 1'b0;
      sdi_p0 <= 1'b0;
      sdi_p1 <= 1'b0;
    end else begin
      sck_p0 <= sck;
      sck_p1 <= sck_p0;
      sck_p2 <= sck_p1;
      sdi_p0 <= sdi;
      sdi_p1 <= sdi_p0;
    end
  end

  assign sck_rise   = sck_p1 & ~sck_p2;
  assign bit_in     = sdi_p1;
  assign frame_full = {shift_q[30:0], bit_in};

  // Saturating idle counter; fires exactly once per quiet period.
  assign timeout_hit = !sck_rise && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (sck_rise) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // ---- stage: frame decode and word writes ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= ST_HUNT;
      zero_cnt          <= '0;
      bit_cnt           <= '0;
      shift_q           <= '0;
      word_cnt          <= '0;
      word_limit        <= '0;
      pend_lo           <= 1'b0;
      bus.write_address <= '0;
      bus.write_data    <= '0;
      bus.write_strobe  <= 1'b0;
      bus.frame_done    <= 1'b0;
      bus.frame_error   <= 1'b0;
    end else begin
      bus.write_strobe <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.frame_error  <= 1'b0;

      // Address advances in the cycle after each issued write.
      if (bus.write_strobe) begin
        bus.write_address <= bus.write_address + AW'(1);
      end

      // Low word follows the high word on the very next cycle. word_cnt
      // already reflects the high-word write, so the limit check is exact.
      if (pend_lo) begin
        pend_lo        <= 1'b0;
        bus.write_data <= shift_q[15:0];
        if (word_cnt != word_limit) begin
          bus.write_strobe <= 1'b1;
          word_cnt         <= word_cnt + AW'(1);
        end
      end

      if (timeout_hit) begin
        if (state != ST_HUNT) begin
          if (word_cnt != '0) begin
            bus.frame_done <= 1'b1;
          end
          state   <= ST_HUNT;
          bit_cnt <= '0;
          shift_q <= '0;
        end
        zero_cnt <= '0;
      end else if (sck_rise) begin
        case (state)
          ST_HUNT: begin
            if (bit_in) begin
              zero_cnt <= '0;
            end else if (zero_cnt == 6'd31) begin
              state             <= ST_ARMED;
              zero_cnt          <= '0;
              bus.write_address <= start_address;
              word_cnt          <= '0;
              word_limit        <= word_count;
            end else begin
              zero_cnt <= zero_cnt + 6'd1;
            end
          end

          ST_ARMED: begin
            // Extra zeros extend the start frame; the first 1 is bit 31.
            if (bit_in) begin
              shift_q <= 32'd1;
              bit_cnt <= 6'd1;
              state   <= ST_DATA;
            end
          end

          ST_DATA: begin
            shift_q <= frame_full;
            if (bit_cnt == 6'd31) begin
              bit_cnt <= '0;
              case (classify(frame_full))
                FR_LED: begin
                  bus.write_data <= frame_full[31:16];
                  pend_lo        <= 1'b1;
                  if (word_cnt != word_limit) begin
                    bus.write_strobe <= 1'b1;
                    word_cnt         <= word_cnt + AW'(1);
                  end
                end
                FR_START: begin
                  bus.frame_done    <= 1'b1;
                  state             <= ST_ARMED;
                  bus.write_address <= start_address;
                  word_cnt          <= '0;
                  word_limit        <= word_count;
                end
                default: begin
                  bus.frame_error <= 1'b1;
                  state           <= ST_HUNT;
                  zero_cnt        <= '0;
                end
              endcase
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end

          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apa102_in.sv
// tb_apa102_in: directed bench for the APA102 stream receiver.
// A vector table drives start frames and frame lists; a frame-level model
// derives the expected write addresses/data, while write/done/error counts
// come from the table. Hand sequences cover reset state, a stalled partial
// frame and reset between the two writes of one frame.
module tb_apa102_in;
  localparam int AW   = 16;
  localparam int TO   = 4800;
  localparam int HALF = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sck = 1'b0;
  logic          sdi = 1'b0;
  logic [AW-1:0] start_address = '0;
  logic [AW-1:0] word_count = '0;

  apa102_in_if #(.ADDRESS_BUS_WIDTH(AW)) bus ();

  apa102_in #(
    .ADDRESS_BUS_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sck(sck),
    .sdi(sdi),
    .start_address(start_address),
    .word_count(word_count),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] log_a[$];
  logic [15:0] log_d[$];
  int          log_c[$];
  int          n_done = 0;
  int          n_err = 0;

  always @(negedge clk) begin
    if (bus.write_strobe) begin
      log_a.push_back(bus.write_address);
      log_d.push_back(bus.write_data);
      log_c.push_back(cyc);
    end
    if (bus.frame_done)  n_done <= n_done + 1;
    if (bus.frame_error) n_err <= n_err + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    repeat (HALF) @(posedge clk);
    sck = 1'b1;
    repeat (HALF) @(posedge clk);
    sck = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic do_reset();
    sck = 1'b0;
    sdi = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  typedef struct {
    int               zeros;
    int               nf;
    logic [15:0]      sa;
    logic [15:0]      wc;
    int               ewr;
    int               edone;
    int               eerr;
    logic [5:0][31:0] fr;
  } vec_t;

  vec_t vt[7];

  task automatic setv(input int k, input int z, input int nf, input logic [15:0] sa,
                      input logic [15:0] wc, input int ewr, input int edone, input int eerr,
                      input logic [31:0] f0, input logic [31:0] f1, input logic [31:0] f2,
                      input logic [31:0] f3, input logic [31:0] f4);
    vt[k].zeros = z;   vt[k].nf = nf;       vt[k].sa = sa;     vt[k].wc = wc;
    vt[k].ewr = ewr;   vt[k].edone = edone; vt[k].eerr = eerr;
    vt[k].fr[0] = f0;  vt[k].fr[1] = f1;    vt[k].fr[2] = f2;
    vt[k].fr[3] = f3;  vt[k].fr[4] = f4;    vt[k].fr[5] = 32'h0;
  endtask

  initial begin
    logic [15:0] ma[$];
    logic [15:0] md[$];
    int          bw, bd, be, got, mst, mcnt, nchk;
    logic [15:0] maddr;
    logic [31:0] f;
    logic [31:0] w;
    bit          seen;

    setv(0, 32, 1, 16'h0100, 16'd4, 2, 1, 0,
         32'hE1FF0080, 32'h0, 32'h0, 32'h0, 32'h0);
    setv(1, 32, 4, 16'h0100, 16'd6, 6, 1, 0,
         32'hFF112233, 32'hFF445566, 32'hFF778899, 32'hFFFFFFFF, 32'h0);
    setv(2, 40, 1, 16'h0100, 16'd4, 2, 1, 0,
         32'hFF123456, 32'h0, 32'h0, 32'h0, 32'h0);
    setv(3, 32, 3, 16'h0200, 16'd8, 4, 2, 0,
         32'hFF010101, 32'h00000000, 32'hFF020202, 32'h0, 32'h0);
    setv(4, 32, 5, 16'h0300, 16'd8, 4, 1, 1,
         32'hFF0A0B0C, 32'h40000001, 32'h00000000, 32'hFF0D0E0F, 32'h0);
    setv(5, 32, 1, 16'h0100, 16'd0, 0, 0, 0,
         32'hFF112233, 32'h0, 32'h0, 32'h0, 32'h0);
    setv(6, 32, 1, 16'hFFFF, 16'd4, 2, 1, 0,
         32'hFFAABBCC, 32'h0, 32'h0, 32'h0, 32'h0);

    // Reset state, sampled while rst is held low.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobe", 32'(bus.write_strobe), 32'd0);
    chk("rst_addr",   32'(bus.write_address), 32'd0);
    chk("rst_data",   32'(bus.write_data), 32'd0);
    chk("rst_done",   32'(bus.frame_done), 32'd0);
    chk("rst_err",    32'(bus.frame_error), 32'd0);

    for (int k = 0; k < 7; k++) begin
      do_reset();
      start_address = vt[k].sa;
      word_count    = vt[k].wc;
      bw = log_a.size();
      bd = n_done;
      be = n_err;
      send_zeros(vt[k].zeros);
      for (int j = 0; j < vt[k].nf; j++) send_word(vt[k].fr[j]);
      repeat (TO + 100) @(posedge clk);

      // Frame-level model: leading zeros always arm the receiver.
      ma.delete();
      md.delete();
      mst = 1; maddr = vt[k].sa; mcnt = 0;
      for (int j = 0; j < vt[k].nf; j++) begin
        f = vt[k].fr[j];
        if (mst == 0) begin
          if (f == 32'h0) begin mst = 1; maddr = vt[k].sa; mcnt = 0; end
        end else if (mst == 1 && f == 32'h0) begin
          mst = 1;
        end else begin
          mst = 2;
          if (f[31:29] == 3'b111) begin
            for (int h = 0; h < 2; h++) begin
              if (mcnt != int'(vt[k].wc)) begin
                ma.push_back(maddr);
                md.push_back(h == 0 ? f[31:16] : f[15:0]);
                maddr = maddr + 16'd1;
                mcnt++;
              end
            end
          end else if (f == 32'h0) begin
            mst = 1; maddr = vt[k].sa; mcnt = 0;
          end else begin
            mst = 0;
          end
        end
      end

      got = log_a.size() - bw;
      chk($sformatf("v%0d_nwrites", k), 32'(got), 32'(vt[k].ewr));
      chk($sformatf("v%0d_ndone", k), 32'(n_done - bd), 32'(vt[k].edone));
      chk($sformatf("v%0d_nerr", k), 32'(n_err - be), 32'(vt[k].eerr));
      nchk = (got < ma.size()) ? got : ma.size();
      for (int i = 0; i < nchk; i++) begin
        chk($sformatf("v%0d_addr%0d", k, i), 32'(log_a[bw + i]), 32'(ma[i]));
        chk($sformatf("v%0d_data%0d", k, i), 32'(log_d[bw + i]), 32'(md[i]));
      end
      for (int i = 0; i + 1 < got; i += 2) begin
        chk($sformatf("v%0d_pair%0d_gap", k, i / 2),
            32'(log_c[bw + i + 1] - log_c[bw + i]), 32'd1);
      end
    end

    // LED frame stalled after 20 bits: timeout, no write, back to hunting.
    do_reset();
    start_address = 16'h0400;
    word_count    = 16'd4;
    bw = log_a.size(); bd = n_done; be = n_err;
    send_zeros(32);
    w = 32'hFF112233;
    for (int i = 31; i >= 12; i--) send_bit(w[i]);
    repeat (TO + 100) @(posedge clk);
    chk("stall_nwrites", 32'(log_a.size() - bw), 32'd0);
    chk("stall_ndone",   32'(n_done - bd), 32'd0);
    chk("stall_nerr",    32'(n_err - be), 32'd0);
    bw = log_a.size();
    send_zeros(32);
    send_word(32'hFF556677);
    repeat (50) @(posedge clk);
    chk("stall_recover_n", 32'(log_a.size() - bw), 32'd2);
    if (log_a.size() - bw >= 2) begin
      chk("stall_recover_a0", 32'(log_a[bw]), 32'h0400);
      chk("stall_recover_d0", 32'(log_d[bw]), 32'hFF55);
      chk("stall_recover_d1", 32'(log_d[bw + 1]), 32'h6677);
    end

    // Reset asserted between the high and low writes of one frame.
    do_reset();
    start_address = 16'h0500;
    word_count    = 16'd4;
    send_zeros(32);
    w = 32'hFFABCDEF;
    for (int i = 31; i >= 1; i--) send_bit(w[i]);
    sdi = w[0];
    repeat (HALF) @(posedge clk);
    sck = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.write_strobe) seen = 1'b1;
    end
    chk("midrst_first_seen", 32'(seen), 32'd1);
    chk("midrst_first_data", 32'(bus.write_data), 32'hFFAB);
    rst = 1'b0;
    #1;
    chk("midrst_strobe", 32'(bus.write_strobe), 32'd0);
    chk("midrst_addr",   32'(bus.write_address), 32'd0);
    chk("midrst_data",   32'(bus.write_data), 32'd0);
    bw = log_a.size();
    sck = 1'b0;
    repeat (3) @(posedge clk);
    rst = 1'b1;
    repeat (30) @(posedge clk);
    chk("midrst_no_second", 32'(log_a.size() - bw), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apa102_in.md
Name: apa102_in

Overview:
APA102 stream receiver: the input-side counterpart of the apa102_out output engines. It samples an external APA102 clock/data pair (for example, from an upstream controller or chained board) and decodes start, LED and end frames. Each LED frame becomes two 16-bit word writes on the same write_address/write_data/write_strobe interface that spi_in presents to sram_bus. This lets a captured pixel stream land in the shared frame memory.

Parameters:
ADDRESS_BUS_WIDTH, 16, width of start_address, word_count and write_address
TIMEOUT_CYCLES, 4800, clk cycles without a synchronized sck rising edge before the receiver abandons the frame (100 us at 48 MHz)

Ports:
clk  input  1  system clock (48 MHz HFOSC)
rst  input  1  asynchronous, active-low reset
sck  input  1  APA102 clock from pin, asynchronous to clk
sdi  input  1  APA102 data from pin, asynchronous to clk
start_address  input  ADDRESS_BUS_WIDTH  first word address written after each start frame
word_count  input  ADDRESS_BUS_WIDTH  maximum words written per refresh; 0 disables all writes
write_address  output  ADDRESS_BUS_WIDTH  word address of the current write
write_data  output  16  word data
write_strobe  output  1  one-clk write pulse
frame_done  output  1  one-clk pulse when a refresh ends
frame_error  output  1  one-clk pulse on a malformed frame

Behaviour:
- Reset (rst low, asynchronous): state HUNT, all counters 0, shift register 0, write_strobe/frame_done/frame_error 0, write_address 0, write_data 0.
- Input capture: sck and sdi each pass through a 2-FF synchronizer. A rising edge is detected with a third sck flop. sdi is sampled on that edge, MSB first.
- Supported sck rate is at most clk/4; faster rates are out of scope.
- State HUNT: counts consecutive 0 bits; any 1 bit clears the count. When the count reaches 32, go to ARMED, load write_address with start_address and clear the word counter.
- State ARMED: further 0 bits are ignored (extended start frame). The first 1 bit is bit 31 of an LED frame; load it into the shift register with bit count 1 and go to DATA.
- State DATA: shift bits until 32 are collected, then classify the frame on the detect cycle N of the 32nd edge:
  - Top 3 bits = 111 (LED frame): emit the high word (bits 31:16) with strobe on N+1 and the low word (bits 15:0) on N+2. write_address increments after each write and wraps modulo 2^ADDRESS_BUS_WIDTH. Stay in DATA.
  - Word limit: a write is suppressed (no strobe, no address increment) once words written equals word_count. Decoding continues, so trailing end-frame 0xFFFFFFFF words are dropped whenever word_count is sized correctly.
  - All 32 bits 0 (new start frame): pulse frame_done on N+1, then go to ARMED with address and word counter reloaded.
  - Any other value: pulse frame_error on N+1, then go to HUNT with the zero count cleared.
- Timeout: a counter clears on every detected sck edge. If it reaches TIMEOUT_CYCLES in ARMED or DATA:
  - Pulse frame_done if at least one word was written since the last start frame.
  - Discard any partial frame and go to HUNT.
  - In HUNT the timeout only clears the zero count.
- Write ordering: the two writes of one frame always occur on consecutive cycles and are never split by a timeout or reset-free event. The next frame's 32nd edge cannot arrive sooner than 128 clk cycles later.
- start_address and word_count are sampled only on the HUNT->ARMED and DATA->ARMED transitions. Changing them mid-refresh has no effect until the next start frame.
- Reset mid-frame: all activity stops immediately, and any pending second write is lost.

Test Plan:
- 32 zeros, frame 0xE1FF0080, start_address=0x0100, word_count=4 -> writes (0x0100, 0xE1FF), then (0x0101, 0x0080) on consecutive cycles; no error.
- 32 zeros, 3 LED frames, 0xFFFFFFFF end frame, word_count=6 -> exactly 6 strobes at 0x0100..0x0105; end frame suppressed; timeout produces one frame_done.
- 40 zeros (extended start), then frame 0xFF123456 -> writes 0xFF12 and 0x3456; the extra 8 zeros produce nothing.
- Refresh followed directly by 32 zeros and a new LED frame -> frame_done pulse; address restarts at start_address.
- Frame 0x40000001 inside DATA -> frame_error pulse, no writes; a following valid start+LED frame is decoded normally.
- Stop sck after 20 bits of an LED frame for >4800 cycles -> no write, return to HUNT. Separately, assert rst between the two writes -> outputs 0 at once and the second write never appears.
